// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Shared types and constants for the fetch/exception sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FETCH_MEM   = 3'd1,
    ST_FETCH_LATCH = 3'd2,
    ST_DONE        = 3'd3,
    ST_EXC_EPC     = 3'd4,
    ST_EXC_MEM     = 3'd5,
    ST_EXC_LATCH   = 3'd6,
    ST_EXC_PC      = 3'd7
  } seq_state_t;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_NOPCODE = 2'b01;
  localparam logic [1:0] EXC_OVF     = 2'b10;
  localparam logic [1:0] EXC_DIV0    = 2'b11;

  localparam logic [1:0] ALU_NOP  = 2'b00;
  localparam logic [1:0] ALU_INC4 = 2'b01;
  localparam logic [1:0] ALU_DEC4 = 2'b10;

  localparam int unsigned DEF_VEC_NOPCODE = 253;
  localparam int unsigned DEF_VEC_OVF     = 254;
  localparam int unsigned DEF_VEC_DIV0    = 255;

  // Fixed priority: nopcode > ovf > div0.
  function automatic logic [1:0] exc_priority(input logic nopcode,
                                              input logic ovf,
                                              input logic div0);
    logic [1:0] code;
    code = EXC_NONE;
    if (nopcode)   code = EXC_NOPCODE;
    else if (ovf)  code = EXC_OVF;
    else if (div0) code = EXC_DIV0;
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_counter
// Brief    : Times the memory read latency; expired on the last wait cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign expired = en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fetch_exc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_exc_sequencer
// Brief    : Moore FSM sequencing instruction fetch and exception entry.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_exc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          MEM_LAT     = 2,
  parameter int unsigned VEC_NOPCODE = DEF_VEC_NOPCODE,
  parameter int unsigned VEC_OVF     = DEF_VEC_OVF,
  parameter int unsigned VEC_DIV0    = DEF_VEC_DIV0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              exc_nopcode,
  input  logic              exc_ovf,
  input  logic              exc_div0,
  output logic              mem_addr_sel,
  output logic [ADDR_W-1:0] mem_exc_addr,
  output logic [1:0]        alu_op,
  output logic              pc_write,
  output logic              pc_src,
  output logic              ir_write,
  output logic              mdr_write,
  output logic              epc_write,
  output logic [1:0]        exc_code,
  output logic              busy,
  output logic              fetch_done
);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("fetch_exc_sequencer: MEM_LAT must be >= 1");
  end

  seq_state_t r_state;
  seq_state_t w_next;
  logic [1:0] r_exc_code;
  logic       w_any_exc;
  logic       w_cnt_clear;
  logic       w_cnt_en;
  logic       w_cnt_expired;

  assign w_any_exc = exc_nopcode | exc_ovf | exc_div0;

  mem_wait_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_wait (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_cnt_clear),
    .en      (w_cnt_en),
    .expired (w_cnt_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The exception code persists after the sequence as "last serviced".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_exc_code <= EXC_NONE;
    end else if (r_state == ST_IDLE && w_any_exc) begin
      r_exc_code <= exc_priority(exc_nopcode, exc_ovf, exc_div0);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_exc)      w_next = ST_EXC_EPC;
        else if (fetch_req) w_next = ST_FETCH_MEM;
      end
      ST_FETCH_MEM:   if (w_cnt_expired) w_next = ST_FETCH_LATCH;
      ST_FETCH_LATCH: w_next = ST_DONE;
      ST_DONE:        w_next = ST_IDLE;
      ST_EXC_EPC:     w_next = ST_EXC_MEM;
      ST_EXC_MEM:     if (w_cnt_expired) w_next = ST_EXC_LATCH;
      ST_EXC_LATCH:   w_next = ST_EXC_PC;
      ST_EXC_PC:      w_next = ST_FETCH_MEM;
      default:        w_next = ST_IDLE;
    endcase
  end

  // Clear on the edge that enters a wait state so the first wait cycle sees 0.
  assign w_cnt_en    = (r_state == ST_FETCH_MEM) || (r_state == ST_EXC_MEM);
  assign w_cnt_clear = ((w_next == ST_FETCH_MEM) && (r_state != ST_FETCH_MEM)) ||
                       ((w_next == ST_EXC_MEM)   && (r_state != ST_EXC_MEM));

  always_comb begin
    mem_addr_sel = 1'b0;
    alu_op       = ALU_NOP;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    epc_write    = 1'b0;
    busy         = 1'b1;
    fetch_done   = 1'b0;
    case (r_state)
      ST_IDLE:      busy = 1'b0;
      ST_FETCH_MEM: mem_addr_sel = 1'b0;
      ST_FETCH_LATCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        alu_op   = ALU_INC4;
      end
      ST_DONE: begin
        busy       = 1'b0;
        fetch_done = 1'b1;
      end
      ST_EXC_EPC: begin
        epc_write = 1'b1;
        alu_op    = ALU_DEC4;
      end
      ST_EXC_MEM:   mem_addr_sel = 1'b1;
      ST_EXC_LATCH: mdr_write = 1'b1;
      ST_EXC_PC: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
      end
      default:      busy = 1'b0;
    endcase
  end

  assign exc_code = r_exc_code;

  always_comb begin
    mem_exc_addr = '0;
    case (r_exc_code)
      EXC_NOPCODE: mem_exc_addr = ADDR_W'(VEC_NOPCODE);
      EXC_OVF:     mem_exc_addr = ADDR_W'(VEC_OVF);
      EXC_DIV0:    mem_exc_addr = ADDR_W'(VEC_DIV0);
      default:     mem_exc_addr = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_exc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_exc_sequencer
// Brief    : Table-driven bench for fetch_exc_sequencer plus reset/latency cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_exc_sequencer;

  // Per-state output word: {sel, alu_op[1:0], pc_write, pc_src, ir_write, mdr_write, epc_write, busy, fetch_done}
  localparam logic [9:0] c_idle = 10'b0_00_0_0_0_0_0_0_0;
  localparam logic [9:0] c_fm   = 10'b0_00_0_0_0_0_0_1_0;
  localparam logic [9:0] c_fl   = 10'b0_01_1_0_1_0_0_1_0;
  localparam logic [9:0] c_dn   = 10'b0_00_0_0_0_0_0_0_1;
  localparam logic [9:0] c_epc  = 10'b0_10_0_0_0_0_1_1_0;
  localparam logic [9:0] c_em   = 10'b1_00_0_0_0_0_0_1_0;
  localparam logic [9:0] c_el   = 10'b0_00_0_0_0_1_0_1_0;
  localparam logic [9:0] c_ep   = 10'b0_00_1_1_0_0_0_1_0;

  typedef struct {
    bit          fr, en, eo, ed;
    logic [9:0]  st;
    logic [1:0]  code;
    logic [31:0] addr;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic fetch_req = 1'b0, exc_nopcode = 1'b0, exc_ovf = 1'b0, exc_div0 = 1'b0;

  logic        mem_addr_sel, pc_write, pc_src, ir_write, mdr_write, epc_write, busy, fetch_done;
  logic [31:0] mem_exc_addr;
  logic [1:0]  alu_op, exc_code;

  logic        l1_sel, l1_pw, l1_ps, l1_ir, l1_mdr, l1_epc, l1_busy, l1_done;
  logic [31:0] l1_addr;
  logic [1:0]  l1_alu, l1_code;
  logic        l4_sel, l4_pw, l4_ps, l4_ir, l4_mdr, l4_epc, l4_busy, l4_done;
  logic [31:0] l4_addr;
  logic [1:0]  l4_alu, l4_code;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clock = ~clock;

  fetch_exc_sequencer #(.ADDR_W(32), .MEM_LAT(2)) dut (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .exc_nopcode(exc_nopcode),
    .exc_ovf(exc_ovf), .exc_div0(exc_div0), .mem_addr_sel(mem_addr_sel),
    .mem_exc_addr(mem_exc_addr), .alu_op(alu_op), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mdr_write(mdr_write), .epc_write(epc_write),
    .exc_code(exc_code), .busy(busy), .fetch_done(fetch_done));

  fetch_exc_sequencer #(.ADDR_W(32), .MEM_LAT(1)) dut_l1 (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .exc_nopcode(exc_nopcode),
    .exc_ovf(exc_ovf), .exc_div0(exc_div0), .mem_addr_sel(l1_sel),
    .mem_exc_addr(l1_addr), .alu_op(l1_alu), .pc_write(l1_pw), .pc_src(l1_ps),
    .ir_write(l1_ir), .mdr_write(l1_mdr), .epc_write(l1_epc),
    .exc_code(l1_code), .busy(l1_busy), .fetch_done(l1_done));

  fetch_exc_sequencer #(.ADDR_W(32), .MEM_LAT(4)) dut_l4 (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .exc_nopcode(exc_nopcode),
    .exc_ovf(exc_ovf), .exc_div0(exc_div0), .mem_addr_sel(l4_sel),
    .mem_exc_addr(l4_addr), .alu_op(l4_alu), .pc_write(l4_pw), .pc_src(l4_ps),
    .ir_write(l4_ir), .mdr_write(l4_mdr), .epc_write(l4_epc),
    .exc_code(l4_code), .busy(l4_busy), .fetch_done(l4_done));

  logic [9:0] w_obs_st;
  assign w_obs_st = {mem_addr_sel, alu_op, pc_write, pc_src, ir_write, mdr_write,
                     epc_write, busy, fetch_done};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {22'd0, w_obs_st, exc_code, mem_exc_addr}, 64'd0);
  endtask

  function automatic vec_t mk(input bit fr, input bit en, input bit eo, input bit ed,
                              input logic [9:0] st, input logic [1:0] code,
                              input logic [31:0] addr);
    vec_t v;
    v.fr = fr; v.en = en; v.eo = eo; v.ed = ed;
    v.st = st; v.code = code; v.addr = addr;
    return v;
  endfunction

  // One fetch_req pulse, then record the cycle each DUT reports fetch_done.
  task automatic measure(input string tag);
    int d2 = -1, d1 = -1, d4 = -1;
    int irc = 0, pwc = 0;
    @(posedge clock); #1 fetch_req = 1'b1;
    @(posedge clock); #1 fetch_req = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin @(posedge clock); #1; end
      @(negedge clock);
      if (fetch_done && d2 < 0) d2 = k;
      if (l1_done && d1 < 0)    d1 = k;
      if (l4_done && d4 < 0)    d4 = k;
      irc += int'(ir_write);
      pwc += int'(pc_write);
    end
    check({tag, " lat2"}, 64'(d2), 64'(4));
    check({tag, " lat1"}, 64'(d1), 64'(3));
    check({tag, " lat4"}, 64'(d4), 64'(6));
    check({tag, " ir_write count"}, 64'(irc), 64'(1));
    check({tag, " pc_write count"}, 64'(pwc), 64'(1));
  endtask

  vec_t tbl[$];

  initial begin
    // cycle-by-cycle vectors: inputs applied in the cycle, outputs observed in it
    tbl.push_back(mk(1,0,0,0, c_idle, 2'd0, 32'd0));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd0, 32'd0));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd0, 32'd0));
    tbl.push_back(mk(0,0,0,0, c_fl,   2'd0, 32'd0));
    tbl.push_back(mk(0,0,0,0, c_dn,   2'd0, 32'd0));
    tbl.push_back(mk(0,0,1,0, c_idle, 2'd0, 32'd0));
    tbl.push_back(mk(0,0,0,0, c_epc,  2'd2, 32'd254));
    tbl.push_back(mk(0,0,0,0, c_em,   2'd2, 32'd254));
    tbl.push_back(mk(0,0,0,0, c_em,   2'd2, 32'd254));
    tbl.push_back(mk(0,0,0,0, c_el,   2'd2, 32'd254));
    tbl.push_back(mk(0,0,0,0, c_ep,   2'd2, 32'd254));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd2, 32'd254));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd2, 32'd254));
    tbl.push_back(mk(0,0,0,0, c_fl,   2'd2, 32'd254));
    tbl.push_back(mk(0,0,0,0, c_dn,   2'd2, 32'd254));
    tbl.push_back(mk(1,1,0,1, c_idle, 2'd2, 32'd254));
    tbl.push_back(mk(1,0,0,1, c_epc,  2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_em,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,1, c_em,   2'd1, 32'd253));
    tbl.push_back(mk(1,0,0,0, c_el,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_ep,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_fl,   2'd1, 32'd253));
    tbl.push_back(mk(1,0,0,0, c_dn,   2'd1, 32'd253));
    tbl.push_back(mk(1,0,0,0, c_idle, 2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_fl,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_dn,   2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,1, c_idle, 2'd1, 32'd253));
    tbl.push_back(mk(0,0,0,0, c_epc,  2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_em,   2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_em,   2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_el,   2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_ep,   2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_fm,   2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_fl,   2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_dn,   2'd3, 32'd255));
    tbl.push_back(mk(0,0,0,0, c_idle, 2'd3, 32'd255));

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset state");
    @(posedge clock); #1 reset = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clock); #1;
      fetch_req = tbl[i].fr; exc_nopcode = tbl[i].en;
      exc_ovf = tbl[i].eo;   exc_div0 = tbl[i].ed;
      @(negedge clock);
      check($sformatf("vec%0d", i), {22'd0, w_obs_st, exc_code, mem_exc_addr},
            {22'd0, tbl[i].st, tbl[i].code, tbl[i].addr});
    end
    @(posedge clock); #1;
    fetch_req = 0; exc_nopcode = 0; exc_ovf = 0; exc_div0 = 0;

    // Reset while in FETCH_MEM: outputs drop at once and IR is never loaded.
    @(posedge clock); #1 fetch_req = 1'b1;
    @(posedge clock); #1 fetch_req = 1'b0;
    check("in fetch_mem before reset", 64'(w_obs_st), 64'(c_fm));
    #2 reset = 1'b1;
    #1 check_all_zero("reset in fetch_mem");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("no ir_write under reset %0d", k), 64'(ir_write), 64'd0);
    end
    @(posedge clock); #1 reset = 1'b0;
    measure("after fetch reset");

    // Reset while in EXC_MEM.
    @(posedge clock); #1 exc_div0 = 1'b1;
    @(posedge clock); #1 exc_div0 = 1'b0;
    @(posedge clock); #1;
    check("in exc_mem before reset", {22'd0, w_obs_st, exc_code, mem_exc_addr},
          {22'd0, c_em, 2'd3, 32'd255});
    #2 reset = 1'b1;
    #1 check_all_zero("reset in exc_mem");
    @(negedge clock);
    check("no ir_write after exc reset", 64'(ir_write), 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    measure("after exc reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_exc_sequencer.md
# fetch_exc_sequencer

Parametrised instruction-fetch and exception-entry sequencer for the multicycle MIPS core. It sits between the main control FSM and the PC/IR/EPC/MDR datapath registers. It runs the fetch sequence (memory read, IR load, PC+4) and the exception entry sequence (EPC save, handler-byte read, PC load), with memory read latency set by a parameter. The main control FSM requests a fetch or raises an exception and waits for `fetch_done`.

## Interface
Parameters:
- `ADDR_W`, 32: address/PC width.
- `MEM_LAT`, 2: memory read latency in cycles; legal range ≥1. `MEM_LAT`=0 is an elaboration error.
- `VEC_NOPCODE`, 253: byte address holding the handler address for an invalid opcode.
- `VEC_OVF`, 254: byte address for the overflow handler.
- `VEC_DIV0`, 255: byte address for the divide-by-zero handler.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `fetch_req` in 1: request a normal fetch; sampled only in IDLE.
- `exc_nopcode`, `exc_ovf`, `exc_div0` in 1 each: exception requests; sampled only in IDLE.
- `mem_addr_sel` out 1: 0 selects PC as the memory address, 1 selects `mem_exc_addr`.
- `mem_exc_addr` out `ADDR_W`: zero-extended vector address for the exception being serviced.
- `alu_op` out 2: PC-ALU operation. 00 none, 01 PC+4, 10 PC−4.
- `pc_write` out 1: PC load enable.
- `pc_src` out 1: 0 selects the ALU result, 1 selects zero-extended MDR[7:0].
- `ir_write`, `mdr_write`, `epc_write` out 1 each: register load enables.
- `exc_code` out 2: last serviced exception. 00 none, 01 nopcode, 10 ovf, 11 div0.
- `busy` out 1: sequence in progress.
- `fetch_done` out 1: one-cycle pulse; IR is valid and PC holds the next address.

## Operation
- Moore FSM. All outputs except `exc_code` and `mem_exc_addr` decode from the registered state only.
- States: IDLE, FETCH_MEM, FETCH_LATCH, DONE, EXC_EPC, EXC_MEM, EXC_LATCH, EXC_PC.
- IDLE:
  - Any exception input asserted → EXC_EPC. Capture `exc_code` with priority nopcode > ovf > div0.
  - Otherwise `fetch_req` asserted → FETCH_MEM.
  - Otherwise stay in IDLE.
  - An exception has priority over a simultaneous `fetch_req`.
- FETCH_MEM:
  - `mem_addr_sel`=0.
  - Held for exactly `MEM_LAT` cycles, timed by the wait counter, then → FETCH_LATCH.
- FETCH_LATCH:
  - `ir_write`=1, `pc_write`=1, `pc_src`=0, `alu_op`=01.
  - → DONE.
- DONE: `fetch_done`=1 → IDLE.
- EXC_EPC:
  - `epc_write`=1, `alu_op`=10. EPC receives PC−4, the address of the faulting instruction.
  - → EXC_MEM.
- EXC_MEM: `mem_addr_sel`=1 for `MEM_LAT` cycles → EXC_LATCH.
- EXC_LATCH: `mdr_write`=1 → EXC_PC.
- EXC_PC: `pc_write`=1, `pc_src`=1 → FETCH_MEM. The handler fetch starts automatically, with no IDLE cycle in between.
- `mem_exc_addr` is a mux of the three vectors selected by `exc_code`. It is 0 when `exc_code`=00.
- Counter:
  - Width `$clog2(MEM_LAT+1)`.
  - Cleared on entry to FETCH_MEM or EXC_MEM; increments each cycle in those states.
  - Exit when count = `MEM_LAT`−1.
- Exception inputs and `fetch_req` arriving outside IDLE are ignored. The requester holds them until `busy`=0.
- `busy`=1 in every state except IDLE and DONE.

## Timing
- Reset, including mid-sequence:
  - State → IDLE immediately; counter → 0; `exc_code` → 00.
  - All outputs 0, `mem_exc_addr`=0.
  - Any partial fetch or exception sequence is abandoned.
- Fetch: `fetch_req` sampled at edge N → `fetch_done` high in cycle N+`MEM_LAT`+2. With `MEM_LAT`=2, that is 4 cycles.
- Exception to handler `fetch_done`: 2·`MEM_LAT`+5 cycles after the sampling edge. With `MEM_LAT`=2, that is 9 cycles.
- `ir_write` and `pc_write` are high for exactly one cycle per fetch.
- `epc_write` is high for exactly one cycle per exception.
- `fetch_req` held high through DONE → a new fetch starts on the edge leaving IDLE. The minimum back-to-back fetch period is `MEM_LAT`+3 cycles.

## Structure
- Package `cpu_ctrl_pkg`:
  - state enum;
  - `exc_code` constants (EXC_NONE/NOPCODE/OVF/DIV0);
  - `alu_op` constants (ALU_NOP/INC4/DEC4);
  - default vector values.
- Sub-module `mem_wait_counter` (parameter `MEM_LAT`):
  - inputs `clear`, `en`;
  - output `expired`.
- The FSM and output decode live in `fetch_exc_sequencer`.

## Test plan
- `MEM_LAT`=2, `fetch_req` pulse at cycle 0:
  - `mem_addr_sel`=0 in cycles 1–2;
  - `ir_write`, `pc_write`, `alu_op`=01 in cycle 3;
  - `fetch_done` in cycle 4;
  - `busy` low in cycles 0 and 4.
- `exc_ovf` in IDLE:
  - `epc_write`, `alu_op`=10 in cycle 1;
  - `mem_exc_addr`=254, `mem_addr_sel`=1 in cycles 2–3;
  - `mdr_write` in cycle 4;
  - `pc_write`, `pc_src`=1 in cycle 5;
  - handler `fetch_done` in cycle 9;
  - `exc_code`=10.
- `exc_nopcode`, `exc_div0` and `fetch_req` together: `exc_code`=01, vector 253, exception path taken.
- `MEM_LAT`=1 and `MEM_LAT`=4: fetch latency 3 and 6 cycles respectively.
- Reset asserted during FETCH_MEM and during EXC_MEM:
  - outputs 0 in the same cycle, with no `ir_write`;
  - a fresh `fetch_req` afterwards completes normally.
- `fetch_req` and `exc_div0` pulsed while `busy`=1: ignored, no extra sequence started.
